x2050_tshift_seq: RTL and testbench

- Multi-step sequencer for the T/F/Q shift datapath. Drives the adder-latch function select (AL) and the advance strobe of the T register block.
- Repeats one AL shift function N times without ROS re-issue, e.g. for multiply/divide iteration and hex normalization.
- In idle it is transparent: the ROS-supplied AL and advance pass straight through.
- Sits between ROS decode and the T register block.

---
 rtl/x2050_tshift_seq.sv | 126 ++++++++++++
 tb/tb_x2050_tshift_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x2050_tshift_seq.sv
// Multi-step sequencer that repeats one AL shift function N times on the T/F/Q datapath.
// Optional step counter output o_steps is enabled by defining X2050_TSHIFT_STEPCNT_EN.
module x2050_tshift_seq #(
    parameter int CNT_W         = 6,
    parameter int NORM_NIBBLE_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_al_ros,
    input  logic             i_ros_advance,
    input  logic             i_start,
    input  logic [4:0]       i_func,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_norm,
    input  logic             i_hold,
    input  logic [31:0]      i_t_reg,
    output logic [4:0]       o_al,
    output logic             o_advance,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_remain,
    output logic             o_norm_hit,
    output logic [1:0]       o_state
`ifdef X2050_TSHIFT_STEPCNT_EN
    ,
    output logic [CNT_W-1:0] o_steps
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [4:0]       r_func;
    logic [CNT_W-1:0] r_remain;
    logic             r_norm;
    logic             r_norm_hit;

    logic w_run;
    logic w_norm_cond;
    logic w_step;
    logic w_unused;

    assign w_run       = (r_state == S_RUN);
    assign w_norm_cond = r_norm & (|i_t_reg[31:32-NORM_NIBBLE_W]);
    // Advance is gated by reset so an aborted run never issues one more step.
    assign w_step      = w_run & i_reset & ~i_hold & ~w_norm_cond;
    assign w_unused    = ^i_t_reg[31-NORM_NIBBLE_W:0];

    always_comb begin
        o_al      = i_al_ros;
        o_advance = i_ros_advance;
        if (r_state != S_IDLE) begin
            o_al      = r_func;
            o_advance = w_step;
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_remain   = r_remain;
    assign o_norm_hit = r_norm_hit;
    assign o_state    = r_state;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_func     <= 5'd0;
            r_remain   <= CNT_ZERO;
            r_norm     <= 1'b0;
            r_norm_hit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_func     <= i_func;
                        r_remain   <= i_count;
                        r_norm     <= i_norm;
                        r_norm_hit <= 1'b0;
                        r_state    <= (i_count != CNT_ZERO) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (w_norm_cond) begin
                        r_norm_hit <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (r_remain == CNT_ZERO) begin
                        r_state <= S_DONE;
                    end else if (!i_hold) begin
                        r_remain <= r_remain - CNT_ONE;
                        if (r_remain == CNT_ONE) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef X2050_TSHIFT_STEPCNT_EN
    logic [CNT_W-1:0] r_steps;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_steps <= CNT_ZERO;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_steps <= CNT_ZERO;
        end else if (w_step && (r_remain != CNT_ZERO)) begin
            r_steps <= r_steps + CNT_ONE;
        end
    end

    assign o_steps = r_steps;
`endif

endmodule

// File: tb/tb_x2050_tshift_seq.sv
// Self-checking bench for x2050_tshift_seq: vector table, directed multi-cycle sequences, random vs model.
module tb_x2050_tshift_seq;

    localparam int CNT_W = 6;

    logic             clk;
    logic             rst_n;
    logic [4:0]       al_ros;
    logic             ros_adv;
    logic             start;
    logic [4:0]       func;
    logic [CNT_W-1:0] count;
    logic             norm;
    logic             hold;
    logic [31:0]      t_reg;
    logic [4:0]       o_al;
    logic             o_advance;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_remain;
    logic             o_norm_hit;
    logic [1:0]       o_state;
`ifdef X2050_TSHIFT_STEPCNT_EN
    logic [CNT_W-1:0] o_steps;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    x2050_tshift_seq #(.CNT_W(CNT_W), .NORM_NIBBLE_W(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_al_ros     (al_ros),
        .i_ros_advance(ros_adv),
        .i_start      (start),
        .i_func       (func),
        .i_count      (count),
        .i_norm       (norm),
        .i_hold       (hold),
        .i_t_reg      (t_reg),
        .o_al         (o_al),
        .o_advance    (o_advance),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_remain     (o_remain),
        .o_norm_hit   (o_norm_hit),
        .o_state      (o_state)
`ifdef X2050_TSHIFT_STEPCNT_EN
        ,
        .o_steps      (o_steps)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        func    = 5'd0;
        count   = '0;
        norm    = 1'b0;
        hold    = 1'b0;
        al_ros  = 5'd0;
        ros_adv = 1'b0;
        t_reg   = 32'd0;
    endtask

    // Issue one start, then run until the done pulse (bounded), counting advances.
    task automatic run_op(input logic [4:0] f, input logic [CNT_W-1:0] n, input logic nm,
                          input logic [31:0] t0, input logic [31:0] hold_mask, input logic shift_t,
                          output int advs, output int dones, output int runcyc);
        logic adv_seen;
        logic done_seen;
        advs = 0; dones = 0; runcyc = 0;
        start = 1'b1; func = f; count = n; norm = nm; t_reg = t0;
        tick();
        start = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            hold = (c < 32) ? hold_mask[c] : 1'b0;
            #1;
            adv_seen = o_advance;
            if (o_advance) advs++;
            if (o_busy && !o_done) runcyc++;
            if (o_done) begin
                dones++;
                done_seen = 1'b1;
            end
            tick();
            if (shift_t && adv_seen) t_reg = t_reg << 4;
            if (done_seen) break;
        end
        hold = 1'b0;
        if (!done_seen) chk("op_done_timeout", 32'd0, 32'd1);
    endtask

    // vector table
    typedef struct {
        logic             start;
        logic [4:0]       func;
        logic [CNT_W-1:0] count;
        logic [4:0]       al_ros;
        logic             ros_adv;
        logic [4:0]       e_al;
        logic             e_adv;
        logic             e_busy;
        logic             e_done;
        logic [CNT_W-1:0] e_rem;
    } vec_t;

    vec_t tbl[11];

    // behavioural reference for the random phase
    int               m_phase;   // 0 idle, 1 repeating, 2 completion cycle
    logic [4:0]       m_func;
    int               m_rem;
    logic             m_norm;
    logic             m_hit;
    int               m_steps;

    task automatic model_reset();
        m_phase = 0; m_func = 5'd0; m_rem = 0; m_norm = 1'b0; m_hit = 1'b0; m_steps = 0;
    endtask

    initial begin
        int advs;
        int dones;
        int runcyc;
        logic [4:0] e_al;
        logic e_adv;
        logic stop;

        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_remain", {26'd0, o_remain}, 32'd0);
        chk("rst_norm_hit", {31'd0, o_norm_hit}, 32'd0);
        rst_n = 1'b1;

        // reset in the middle of a run
        run_op(5'd3, 6'd10, 1'b0, 32'd0, 32'hFFFF_FFFF, 1'b0, advs, dones, runcyc);
        idle_inputs();
        start = 1'b1; func = 5'd3; count = 6'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        #1;
        chk("rstrun_adv", {31'd0, o_advance}, 32'd0);
        chk("rstrun_busy", {31'd0, o_busy}, 32'd0);
        chk("rstrun_remain", {26'd0, o_remain}, 32'd0);
        tick();
        rst_n = 1'b1;
        al_ros = 5'd5; ros_adv = 1'b1;
        #1;
        chk("pass_al", {27'd0, o_al}, 32'd5);
        chk("pass_adv", {31'd0, o_advance}, 32'd1);
        tick();

        // cycle-by-cycle vectors: basic repeat of 4, zero count, ignored starts
        tbl[0]  = '{1'b0, 5'd0,  6'd0, 5'd5, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b1, 5'd12, 6'd4, 5'd3, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 6'd0};
        tbl[2]  = '{1'b1, 5'd1,  6'd9, 5'd7, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 6'd4};
        tbl[3]  = '{1'b0, 5'd0,  6'd0, 5'd7, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 6'd3};
        tbl[4]  = '{1'b0, 5'd0,  6'd0, 5'd7, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 6'd2};
        tbl[5]  = '{1'b0, 5'd0,  6'd0, 5'd7, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 6'd1};
        tbl[6]  = '{1'b1, 5'd4,  6'd7, 5'd7, 1'b1, 5'd12, 1'b0, 1'b1, 1'b1, 6'd0};
        tbl[7]  = '{1'b0, 5'd0,  6'd0, 5'd9, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, 6'd0};
        tbl[8]  = '{1'b1, 5'd2,  6'd0, 5'd1, 1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 6'd0};
        tbl[9]  = '{1'b1, 5'd6,  6'd5, 5'd8, 1'b1, 5'd2,  1'b0, 1'b1, 1'b1, 6'd0};
        tbl[10] = '{1'b0, 5'd0,  6'd0, 5'd4, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0, 6'd0};
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].start; func = tbl[i].func; count = tbl[i].count;
            al_ros = tbl[i].al_ros; ros_adv = tbl[i].ros_adv;
            #1;
            chk($sformatf("vec%0d_al", i), {27'd0, o_al}, {27'd0, tbl[i].e_al});
            chk($sformatf("vec%0d_adv", i), {31'd0, o_advance}, {31'd0, tbl[i].e_adv});
            chk($sformatf("vec%0d_busy", i), {31'd0, o_busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("vec%0d_done", i), {31'd0, o_done}, {31'd0, tbl[i].e_done});
            chk($sformatf("vec%0d_rem", i), {26'd0, o_remain}, {26'd0, tbl[i].e_rem});
            tick();
        end
        idle_inputs();

        // hold on the 2nd and 3rd run cycles
        run_op(5'd6, 6'd3, 1'b0, 32'd0, 32'h0000_0006, 1'b0, advs, dones, runcyc);
        chk("hold_advs", advs, 32'd3);
        chk("hold_runcyc", runcyc, 32'd5);
        chk("hold_dones", dones, 32'd1);
        chk("hold_remain", {26'd0, o_remain}, 32'd0);

        // normalize stop, T shifted left a nibble per advance
        run_op(5'd16, 6'd8, 1'b1, 32'h0000_3000, 32'd0, 1'b1, advs, dones, runcyc);
        chk("norm_advs", advs, 32'd4);
        chk("norm_hit", {31'd0, o_norm_hit}, 32'd1);
        chk("norm_remain", {26'd0, o_remain}, 32'd4);
        chk("norm_busy_after", {31'd0, o_busy}, 32'd0);
`ifdef X2050_TSHIFT_STEPCNT_EN
        chk("norm_steps", {26'd0, o_steps}, 32'd4);
`endif
        // norm already true at first run cycle: zero steps
        run_op(5'd16, 6'd5, 1'b1, 32'h1000_0000, 32'd0, 1'b0, advs, dones, runcyc);
        chk("norm0_advs", advs, 32'd0);
        chk("norm0_remain", {26'd0, o_remain}, 32'd5);
        chk("norm0_hit", {31'd0, o_norm_hit}, 32'd1);

        // zero count clears the sticky norm hit
        run_op(5'd2, 6'd0, 1'b0, 32'd0, 32'd0, 1'b0, advs, dones, runcyc);
        chk("zero_advs", advs, 32'd0);
        chk("zero_dones", dones, 32'd1);
        chk("zero_hit_cleared", {31'd0, o_norm_hit}, 32'd0);
`ifdef X2050_TSHIFT_STEPCNT_EN
        chk("zero_steps", {26'd0, o_steps}, 32'd0);
`endif

        // full-width count
        run_op(5'd9, 6'd63, 1'b0, 32'd0, 32'd0, 1'b0, advs, dones, runcyc);
        chk("max_advs", advs, 32'd63);
        chk("max_dones", dones, 32'd1);
        chk("max_remain", {26'd0, o_remain}, 32'd0);
`ifdef X2050_TSHIFT_STEPCNT_EN
        chk("max_steps", {26'd0, o_steps}, 32'd63);
`endif

        // random stimulus against the reference
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            start   = ($urandom_range(0, 3) == 0);
            func    = 5'($urandom_range(0, 31));
            count   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
            norm    = 1'($urandom_range(0, 1));
            hold    = ($urandom_range(0, 3) == 0);
            al_ros  = 5'($urandom_range(0, 31));
            ros_adv = 1'($urandom_range(0, 1));
            t_reg   = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0FFF_FFFF);
            #1;
            stop = m_norm && (t_reg[31:28] != 4'd0);
            if (m_phase == 0) begin
                e_al = al_ros; e_adv = ros_adv;
            end else if (m_phase == 1) begin
                e_al = m_func; e_adv = rst_n && !hold && !stop;
            end else begin
                e_al = m_func; e_adv = 1'b0;
            end
            chk("rnd_al", {27'd0, o_al}, {27'd0, e_al});
            chk("rnd_adv", {31'd0, o_advance}, {31'd0, e_adv});
            chk("rnd_busy", {31'd0, o_busy}, (m_phase != 0) ? 32'd1 : 32'd0);
            chk("rnd_done", {31'd0, o_done}, (m_phase == 2) ? 32'd1 : 32'd0);
            chk("rnd_remain", {26'd0, o_remain}, m_rem);
            chk("rnd_norm_hit", {31'd0, o_norm_hit}, {31'd0, m_hit});
`ifdef X2050_TSHIFT_STEPCNT_EN
            chk("rnd_steps", {26'd0, o_steps}, m_steps);
`endif
            if (!rst_n) begin
                model_reset();
            end else if (m_phase == 0) begin
                if (start) begin
                    m_func = func; m_rem = int'(count); m_norm = norm; m_hit = 1'b0; m_steps = 0;
                    m_phase = (count == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (stop) begin
                    m_hit = 1'b1;
                    m_phase = 2;
                end else if (!hold) begin
                    m_rem--;
                    m_steps++;
                    if (m_rem == 0) m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
